// File: rtl/dht11_responder_if.sv
// Data-line and payload bundle between the DHT11 responder and its host side.
// slave = responder view, master = host / board view.
interface dht11_responder_if;
    logic       dht_in;
    logic       dht_oe;
    logic [7:0] humi_int;
    logic [7:0] humi_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       bad_sum;
    logic       busy;
    logic       frame_done;
    logic       collision;

    modport slave (
        input  dht_in, humi_int, humi_dec, temp_int, temp_dec, bad_sum,
        output dht_oe, busy, frame_done, collision
    );

    modport master (
        output dht_in, humi_int, humi_dec, temp_int, temp_dec, bad_sum,
        input  dht_oe, busy, frame_done, collision
    );
endinterface

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with the response preamble and a
// 40-bit frame, MSB first, open-drain; no backpressure, timing is set by the us prescaler.
module dht11_responder #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_MIN_US  = 18000,
    parameter int TURNAROUND_US = 20,
    parameter int RESP_LOW_US   = 80,
    parameter int RESP_HIGH_US  = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70,
    parameter int COLL_GUARD_US = 5
) (
    input  logic             clk,
    input  logic             rst,
    dht11_responder_if.slave bus
);
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, WAIT_RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state_q;
    logic [2:0]    sync_q;   // [0],[1] synchronizer stages, [2] previous synchronized level
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   us_cnt_q, us_cnt_d;
    logic [39:0]   frame_q;
    logic [5:0]    idx_q;
    logic          dht_oe_q, busy_q, frame_done_q, collision_q;

    logic          line_s, fall_s, rise_s, us_tick, phase_end, coll_hit;
    logic [15:0]   phase_len;
    logic [7:0]    sum_c;

    assign line_s  = sync_q[1];
    assign fall_s  = sync_q[2] & ~sync_q[1];
    assign rise_s  = ~sync_q[2] & sync_q[1];
    assign us_tick = (pre_q == PW'(CLKS_PER_US - 1));
    assign pre_d   = us_tick ? '0 : pre_q + PW'(1);
    assign us_cnt_d = (us_tick && us_cnt_q != 16'hFFFF) ? us_cnt_q + 16'd1 : us_cnt_q;
    assign sum_c   = bus.humi_int + bus.humi_dec + bus.temp_int + bus.temp_dec;

    always_comb begin
        phase_len = 16'hFFFF;
        case (state_q)
            WAIT_RELEASE: phase_len = 16'(TURNAROUND_US);
            RESP_LOW:     phase_len = 16'(RESP_LOW_US);
            RESP_HIGH:    phase_len = 16'(RESP_HIGH_US);
            BIT_LOW:      phase_len = 16'(BIT_LOW_US);
            BIT_HIGH:     phase_len = frame_q[idx_q] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
            END_LOW:      phase_len = 16'(BIT_LOW_US);
            default:      phase_len = 16'hFFFF;
        endcase
    end

    // Phase ends on the N-th tick after entry; a foreign low past the guard beats it.
    assign phase_end = us_tick && (us_cnt_q >= phase_len - 16'd1);
    assign coll_hit  = (state_q == RESP_HIGH || state_q == BIT_HIGH) && !line_s
                       && (us_cnt_q >= 16'(COLL_GUARD_US));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            pre_q        <= '0;
            us_cnt_q     <= '0;
            frame_q      <= '0;
            idx_q        <= '0;
            dht_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], bus.dht_in};
            pre_q        <= pre_d;
            us_cnt_q     <= us_cnt_d;
            frame_done_q <= 1'b0;
            collision_q  <= 1'b0;
            case (state_q)
                IDLE: if (fall_s) begin
                    state_q  <= HOST_LOW;
                    us_cnt_q <= '0;
                end
                HOST_LOW: if (rise_s) begin
                    us_cnt_q <= '0;
                    if (us_cnt_q >= 16'(START_MIN_US)) begin
                        state_q <= WAIT_RELEASE;
                        busy_q  <= 1'b1;
                        frame_q <= {bus.humi_int, bus.humi_dec, bus.temp_int, bus.temp_dec,
                                    sum_c ^ {8{bus.bad_sum}}};
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_RELEASE: if (fall_s) begin
                    state_q  <= HOST_LOW;
                    busy_q   <= 1'b0;
                    us_cnt_q <= '0;
                end else if (phase_end) begin
                    state_q  <= RESP_LOW;
                    dht_oe_q <= 1'b1;
                    us_cnt_q <= '0;
                end
                RESP_LOW: if (phase_end) begin
                    state_q  <= RESP_HIGH;
                    dht_oe_q <= 1'b0;
                    us_cnt_q <= '0;
                end
                RESP_HIGH, BIT_HIGH: if (coll_hit) begin
                    state_q     <= HOST_LOW;
                    dht_oe_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    collision_q <= 1'b1;
                    us_cnt_q    <= '0;
                end else if (phase_end) begin
                    dht_oe_q <= 1'b1;
                    us_cnt_q <= '0;
                    if (state_q == RESP_HIGH) begin
                        state_q <= BIT_LOW;
                        idx_q   <= 6'd39;
                    end else if (idx_q == 6'd0) begin
                        state_q <= END_LOW;
                    end else begin
                        state_q <= BIT_LOW;
                        idx_q   <= idx_q - 6'd1;
                    end
                end
                BIT_LOW: if (phase_end) begin
                    state_q  <= BIT_HIGH;
                    dht_oe_q <= 1'b0;
                    us_cnt_q <= '0;
                end
                END_LOW: if (phase_end) begin
                    state_q      <= IDLE;
                    dht_oe_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                    us_cnt_q     <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dht_oe     = dht_oe_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.collision  = collision_q;
endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a driver plays the host, a monitor decodes the line and
// scores each frame_done / collision event against a queue of expected events.
module tb_dht11_responder;
    localparam int C        = 2;
    localparam int START_US = 200;
    localparam int LONG_US  = 210;

    typedef struct {
        bit          coll;
        logic [39:0] data;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, host_low = 1'b0;
    int   n_chk = 0, n_err = 0;
    exp_t sb[$];

    dht11_responder_if ifc();
    assign ifc.dht_in = ~(ifc.dht_oe | host_low);

    always #5 clk = ~clk;

    dht11_responder #(.CLKS_PER_US(C), .START_MIN_US(START_US)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        n_chk++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    function automatic bit in_tol(input int got, input int us);
        return (got >= (us - 1) * C) && (got <= (us + 1) * C);
    endfunction

    // ---------------- monitor ----------------
    int   cyc = 0, last_chg = 0, rise_cyc = 0, ta_len = 0;
    logic oe_prev = 1'b0, busy_prev = 1'b0;
    bit   in_frame = 1'b0;
    int   lows[$];
    int   highs[$];
    exp_t mon_e;

    task automatic score_frame(input logic [39:0] exp_d);
        logic [39:0] got_d;
        int bad_lo, bad_hi;
        got_d  = '0;
        bad_lo = 0;
        bad_hi = 0;
        check("phase_count", {lows.size(), highs.size()}, {32'd42, 32'd41});
        if (lows.size() == 42 && highs.size() == 41) begin
            check_rng("turnaround", ta_len, 19 * C, 21 * C);
            check_rng("resp_low", lows[0], 79 * C, 81 * C);
            check_rng("resp_high", highs[0], 79 * C, 81 * C);
            check_rng("end_low", lows[41], 49 * C, 51 * C);
            for (int k = 0; k < 40; k++) begin
                got_d[39 - k] = (highs[k + 1] > 48 * C);
                if (!in_tol(lows[k + 1], 50)) bad_lo++;
                if (!in_tol(highs[k + 1], exp_d[39 - k] ? 70 : 26)) bad_hi++;
            end
            check("bit_low_timing_bad", bad_lo, 0);
            check("bit_high_timing_bad", bad_hi, 0);
            check("frame_data", got_d, exp_d);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
            lows.delete();
            highs.delete();
            oe_prev   = 1'b0;
            busy_prev = 1'b0;
            last_chg  = cyc;
        end else begin
            if (ifc.busy && !busy_prev) begin
                in_frame = 1'b1;
                lows.delete();
                highs.delete();
                rise_cyc = cyc;
                ta_len   = 0;
            end
            if (ifc.dht_oe !== oe_prev) begin
                if (in_frame) begin
                    if (!ifc.dht_oe) lows.push_back(cyc - last_chg);
                    else if (lows.size() == 0) ta_len = cyc - rise_cyc;
                    else highs.push_back(cyc - last_chg);
                end
                last_chg = cyc;
            end
            if (ifc.collision) begin
                if (sb.size() == 0) begin
                    check("unexpected_collision", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_is_collision", mon_e.coll, 1);
                    check("collision_oe_busy", {ifc.dht_oe, ifc.busy}, 2'b00);
                end
                in_frame = 1'b0;
            end
            if (ifc.frame_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_is_frame", mon_e.coll, 0);
                    check("busy_at_done", ifc.busy, 0);
                    score_frame(mon_e.data);
                end
                in_frame = 1'b0;
            end
            oe_prev   = ifc.dht_oe;
            busy_prev = ifc.busy;
        end
    end

    // ---------------- driver ----------------
    task automatic set_data(input logic [7:0] hi, input logic [7:0] hd,
                            input logic [7:0] ti, input logic [7:0] td, input logic bs);
        ifc.humi_int = hi;
        ifc.humi_dec = hd;
        ifc.temp_int = ti;
        ifc.temp_dec = td;
        ifc.bad_sum  = bs;
    endtask

    task automatic push_exp(input bit coll, input logic [39:0] data);
        exp_t e;
        e.coll = coll;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic host_start(input int us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (us * C) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_sb(input string name);
        for (int i = 0; i < 20000; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(name, sb.size(), 0);
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_oe(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (ifc.dht_oe) break;
            @(negedge clk);
        end
        check(name, ifc.dht_oe, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet, falls;
        logic oe_p;
        set_data(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs", {ifc.dht_oe, ifc.busy, ifc.frame_done, ifc.collision}, 4'b0000);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // nominal frame
        set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        push_exp(1'b0, 40'h37_00_19_05_55);
        host_start(LONG_US);
        wait_sb("t1_frame_seen");

        // all-ones humidity byte, checksum 0xFF
        set_data(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        push_exp(1'b0, 40'hFF_00_00_00_FF);
        host_start(LONG_US);
        wait_sb("t2_frame_seen");

        // short start: no response at all
        host_start(50);
        quiet = 0;
        repeat (400) begin
            @(negedge clk);
            if (ifc.dht_oe || ifc.busy) quiet++;
        end
        check("t3_short_start_quiet", quiet, 0);

        // bad checksum, inputs changed mid-frame
        set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
        push_exp(1'b0, 40'h37_00_19_05_AA);
        host_start(LONG_US);
        wait_oe("t4_response_start");
        set_data(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        wait_sb("t4_frame_seen");

        // collision 10 us into the high phase of bit index 34 (7th released phase)
        set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        push_exp(1'b1, 40'h0);
        host_start(LONG_US);
        falls = 0;
        oe_p  = 1'b0;
        for (int i = 0; i < 20000 && falls < 7; i++) begin
            @(negedge clk);
            if (oe_p && !ifc.dht_oe) falls++;
            oe_p = ifc.dht_oe;
        end
        check("t5_reached_bit_phase", falls, 7);
        repeat (10 * C) @(negedge clk);
        host_low = 1'b1;
        repeat (20 * C) @(negedge clk);
        host_low = 1'b0;
        wait_sb("t5_collision_seen");
        push_exp(1'b0, 40'h37_00_19_05_55);
        host_start(LONG_US);
        wait_sb("t5_fresh_frame_seen");

        // reset during the response low
        set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        host_start(LONG_US);
        wait_oe("t6_response_start");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_edge_outputs", {ifc.dht_oe, ifc.busy, ifc.frame_done, ifc.collision}, 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        set_data(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        push_exp(1'b0, 40'h12_34_56_78_14);
        host_start(LONG_US);
        wait_sb("t6_after_reset_frame_seen");

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
